// File: rtl/operand_bank_arbiter_if.sv
// Collector/register-file side bundle of the operand bank arbiter.
// slave = arbiter view, master = collector + register-file view.
interface operand_bank_arbiter_if #(
  parameter int unsigned NUM_COLLECTORS = 4,
  parameter int unsigned NUM_RS         = 3,
  parameter int unsigned NUM_BANKS      = 4,
  parameter int unsigned REG_NUM_WIDTH  = 5,
  parameter int unsigned WARP_NUM_WIDTH = 4,
  parameter int unsigned WARP_REG_WIDTH = 1024
);
  localparam int unsigned CollW = (NUM_COLLECTORS > 1) ? $clog2(NUM_COLLECTORS) : 1;
  localparam int unsigned RsW   = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;
  localparam int unsigned AddrW = WARP_NUM_WIDTH + REG_NUM_WIDTH;

  logic [NUM_COLLECTORS*NUM_RS-1:0]               req_valid;
  logic [NUM_COLLECTORS*NUM_RS*REG_NUM_WIDTH-1:0] req_reg;
  logic [NUM_COLLECTORS*WARP_NUM_WIDTH-1:0]       req_warp;
  logic [NUM_COLLECTORS*NUM_RS-1:0]               req_gnt;
  logic [NUM_BANKS-1:0]                           bank_rd_en;
  logic [NUM_BANKS*AddrW-1:0]                     bank_rd_addr;
  logic [NUM_BANKS*WARP_REG_WIDTH-1:0]            bank_rd_data;
  logic [NUM_BANKS-1:0]                           resp_valid;
  logic [NUM_BANKS*CollW-1:0]                     resp_collector;
  logic [NUM_BANKS*RsW-1:0]                       resp_rs;
  logic [NUM_BANKS*WARP_REG_WIDTH-1:0]            resp_data;

  modport slave (
    input  req_valid, req_reg, req_warp, bank_rd_data,
    output req_gnt, bank_rd_en, bank_rd_addr, resp_valid, resp_collector, resp_rs, resp_data
  );

  modport master (
    output req_valid, req_reg, req_warp, bank_rd_data,
    input  req_gnt, bank_rd_en, bank_rd_addr, resp_valid, resp_collector, resp_rs, resp_data
  );
endinterface

// File: rtl/operand_bank_arbiter.sv
// Per-bank round-robin arbiter between operand collectors and a banked register file.
// Zero-latency grant; the {collector, rs} tag follows the 1-cycle bank read.
module operand_bank_arbiter #(
  parameter int unsigned NUM_COLLECTORS = 4,
  parameter int unsigned NUM_RS         = 3,
  parameter int unsigned NUM_BANKS      = 4,
  parameter int unsigned REG_NUM_WIDTH  = 5,
  parameter int unsigned WARP_NUM_WIDTH = 4,
  parameter int unsigned WARP_REG_WIDTH = 1024
) (
  input logic                   clk,
  input logic                   rst,
  operand_bank_arbiter_if.slave bus
);
  localparam int unsigned CollW = (NUM_COLLECTORS > 1) ? $clog2(NUM_COLLECTORS) : 1;
  localparam int unsigned RsW   = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;
  localparam int unsigned BankW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int unsigned AddrW = WARP_NUM_WIDTH + REG_NUM_WIDTH;

  logic [BankW-1:0]                 req_bank [NUM_COLLECTORS][NUM_RS];
  logic [NUM_COLLECTORS*NUM_RS-1:0] gnt;
  logic [NUM_BANKS-1:0]             rd_en;
  logic [NUM_BANKS*AddrW-1:0]       rd_addr;
  logic [CollW-1:0]                 win_c [NUM_BANKS];
  logic [RsW-1:0]                   win_r [NUM_BANKS];

  logic [CollW-1:0]                 ptr_q [NUM_BANKS];
  logic [NUM_BANKS-1:0]             resp_valid_q;
  logic [CollW-1:0]                 resp_coll_q [NUM_BANKS];
  logic [RsW-1:0]                   resp_rs_q [NUM_BANKS];

  function automatic int unsigned rr_idx(input logic [CollW-1:0] ptr, input int unsigned k);
    return (int'(ptr) + k) % NUM_COLLECTORS;
  endfunction

  // Only the low bank-select bits matter; the carry out of them is dropped.
  always_comb begin
    for (int c = 0; c < NUM_COLLECTORS; c++) begin
      for (int r = 0; r < NUM_RS; r++) begin
        req_bank[c][r] = bus.req_reg[(c*NUM_RS+r)*REG_NUM_WIDTH +: BankW] +
                         bus.req_warp[c*WARP_NUM_WIDTH +: BankW];
      end
    end
  end

  always_comb begin
    gnt     = '0;
    rd_en   = '0;
    rd_addr = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      win_c[b] = '0;
      win_r[b] = '0;
    end
    for (int b = 0; b < NUM_BANKS; b++) begin
      for (int k = 0; k < NUM_COLLECTORS; k++) begin
        for (int r = 0; r < NUM_RS; r++) begin
          if (!rd_en[b] && bus.req_valid[rr_idx(ptr_q[b], k)*NUM_RS + r] &&
              (int'(req_bank[rr_idx(ptr_q[b], k)][r]) == b)) begin
            rd_en[b]                        = 1'b1;
            gnt[rr_idx(ptr_q[b], k)*NUM_RS + r] = 1'b1;
            win_c[b]                        = CollW'(rr_idx(ptr_q[b], k));
            win_r[b]                        = RsW'(r);
            rd_addr[b*AddrW +: AddrW] = {
              bus.req_warp[rr_idx(ptr_q[b], k)*WARP_NUM_WIDTH +: WARP_NUM_WIDTH],
              bus.req_reg[(rr_idx(ptr_q[b], k)*NUM_RS + r)*REG_NUM_WIDTH +: REG_NUM_WIDTH]
            };
          end
        end
      end
    end
  end

  // Reset masks the grant in the same cycle so no read or tag escapes.
  assign bus.req_gnt      = rst ? '0 : gnt;
  assign bus.bank_rd_en   = rst ? '0 : rd_en;
  assign bus.bank_rd_addr = rst ? '0 : rd_addr;
  assign bus.resp_data    = bus.bank_rd_data;
  assign bus.resp_valid   = resp_valid_q;

  always_comb begin
    bus.resp_collector = '0;
    bus.resp_rs        = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      bus.resp_collector[b*CollW +: CollW] = resp_coll_q[b];
      bus.resp_rs[b*RsW +: RsW]            = resp_rs_q[b];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid_q <= '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
        ptr_q[b]       <= '0;
        resp_coll_q[b] <= '0;
        resp_rs_q[b]   <= '0;
      end
    end else begin
      resp_valid_q <= rd_en;
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (rd_en[b]) begin
          resp_coll_q[b] <= win_c[b];
          resp_rs_q[b]   <= win_r[b];
          ptr_q[b]       <= (win_c[b] == CollW'(NUM_COLLECTORS - 1)) ? '0 : win_c[b] + 1'b1;
        end
      end
    end
  end
endmodule
